// File: rtl/clap_pkg.sv
// Shared definitions for the clap pattern generator and the clap detector bench:
// FSM state encoding, quiet-level default, noise LFSR constants, latched burst config.
package clap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLAP   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } clap_state_e;

  localparam logic [9:0] DEFAULT_BASELINE = 10'h200;

  // 10-bit Fibonacci LFSR, x^10 + x^7 + 1 (feedback from bits 9 and 6)
  localparam logic [9:0] LFSR_SEED = 10'h155;
  localparam logic [9:0] LFSR_TAPS = 10'h240;

  // Burst parameters captured on accept; lengths stored as (len-1) with 0 mapped to 1
  typedef struct packed {
    logic [9:0]  level;
    logic [7:0]  clap_last;
    logic [11:0] gap_last;
  } burst_cfg_t;

  // Add a signed 3-bit dither to a 10-bit level, clamping to 0..1023
  function automatic logic [9:0] dither_sat(input logic [9:0] base, input logic [2:0] d);
    logic signed [11:0] sum;
    sum = signed'({2'b00, base}) + signed'({{9{d[2]}}, d});
    if (sum < 12'sd0)         return 10'h000;
    else if (sum > 12'sd1023) return 10'h3FF;
    else                      return sum[9:0];
  endfunction

endpackage

// File: rtl/clap_pattern_gen_sample_tick.sv
// sample_tick: divides clk_48 down to one tick every TICK_DIV cycles.
// The tick is high during the last cycle of each sample period; restart
// realigns the period so a new burst's first sample gets full length.
module sample_tick #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk_48,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running modulo-TICK_DIV counter, cleared by reset or restart
  always_ff @(posedge clk_48) begin
    if (rst || restart) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/clap_pattern_gen.sv
// clap_pattern_gen: emits bursts of rectangular "clap" pulses on a 10-bit
// mic-sample stream, separated by quiet gaps at BASELINE.
// Optional feature: define CLAP_NOISE_EN to add LFSR dither to the quiet level.
module clap_pattern_gen
  import clap_pkg::*;
#(
  parameter logic [9:0]  BASELINE = DEFAULT_BASELINE,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic        clk_48,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  num_claps,
  input  logic [7:0]  clap_len,
  input  logic [11:0] gap_len,
  input  logic [9:0]  clap_level,
  output logic [9:0]  mic_sample,
  output logic        busy,
  output logic        done
);

  clap_state_e state;
  burst_cfg_t  cfg;
  logic [7:0]  clap_cnt;
  logic [11:0] gap_cnt;
  logic [2:0]  claps_rem;
  logic [9:0]  quiet;
  logic        tick;
  logic        accept;

  assign accept = (state == IDLE) && start;

  sample_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_48  (clk_48),
    .rst     (rst),
    .restart (accept),
    .tick    (tick)
  );

`ifdef CLAP_NOISE_EN
  logic [9:0] lfsr;

  // Noise source, stepped once per emitted sample
  always_ff @(posedge clk_48) begin
    if (rst)       lfsr <= LFSR_SEED;
    else if (tick) lfsr <= {lfsr[8:0], ^(lfsr & LFSR_TAPS)};
  end

  assign quiet = dither_sat(BASELINE, lfsr[2:0]);
`else
  assign quiet = BASELINE;
`endif

  // Burst sequencer: state, sample/gap/clap counters and registered outputs
  always_ff @(posedge clk_48) begin
    if (rst) begin
      state      <= IDLE;
      cfg        <= '0;
      clap_cnt   <= '0;
      gap_cnt    <= '0;
      claps_rem  <= '0;
      mic_sample <= BASELINE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mic_sample <= quiet;
          if (start) begin
            cfg.level     <= clap_level;
            cfg.clap_last <= (clap_len == 8'd0)  ? 8'd0  : clap_len - 8'd1;
            cfg.gap_last  <= (gap_len  == 12'd0) ? 12'd0 : gap_len  - 12'd1;
            clap_cnt      <= '0;
            gap_cnt       <= '0;
            if (num_claps == 3'd0) begin
              // Nothing to emit: straight to the single done cycle
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state      <= CLAP;
              busy       <= 1'b1;
              mic_sample <= clap_level;
              claps_rem  <= num_claps - 3'd1;
            end
          end
        end

        CLAP: begin
          if (tick) begin
            if (clap_cnt == cfg.clap_last) begin
              clap_cnt   <= '0;
              mic_sample <= quiet;
              if (claps_rem == 3'd0) begin
                state <= FINISH;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              clap_cnt <= clap_cnt + 8'd1;
            end
          end
        end

        GAP: begin
          mic_sample <= quiet;
          if (tick) begin
            if (gap_cnt == cfg.gap_last) begin
              gap_cnt    <= '0;
              claps_rem  <= claps_rem - 3'd1;
              state      <= CLAP;
              mic_sample <= cfg.level;
            end else begin
              gap_cnt <= gap_cnt + 12'd1;
            end
          end
        end

        FINISH: begin
          // done was raised on entry; this cycle ignores start by construction
          mic_sample <= quiet;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
